pipelined_memory: RTL and testbench

Parametrised main-memory model behind the L1 caches, successor to the fixed single-request memory. Adds synchronous reset, a valid/ready request handshake, up to MAX_OUTSTANDING pipelined requests with fixed in-order latency, and two store modes: full-line eviction and single-word write. Every request, load or store, returns exactly one response.

---
 rtl/mem_pkg.sv | 30 +++
 rtl/mem_resp_pipe.sv | 40 ++++
 rtl/pipelined_memory.sv | 91 +++++++++
 tb/tb_pipelined_memory.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types, derived constants and address decode helpers for the pipelined main-memory model.
// Line, word and address widths are configured here; the top module parametrises depth, latency and outstanding limit.
package mem_pkg;

    localparam int FILL_DATA_WIDTH  = 128;
    localparam int STORE_DATA_WIDTH = 32;
    localparam int ADDRESS_WIDTH    = 32;

    localparam int OFFSET   = $clog2(FILL_DATA_WIDTH / 8);
    localparam int WORD_OFF = $clog2(STORE_DATA_WIDTH / 8);
    localparam int WORDS    = FILL_DATA_WIDTH / STORE_DATA_WIDTH;

    typedef struct packed {
        logic                       valid;
        logic                       store;
        logic [ADDRESS_WIDTH-1:0]   address;
        logic [FILL_DATA_WIDTH-1:0] data;
    } mem_stage_t;

    // Bits above the line index are dropped, so upper addresses alias onto the same line.
    function automatic logic [ADDRESS_WIDTH-1:0] line_index(input logic [ADDRESS_WIDTH-1:0] addr,
                                                            input int unsigned              lines);
        return (addr >> OFFSET) & ADDRESS_WIDTH'(lines - 1);
    endfunction

    function automatic logic [ADDRESS_WIDTH-1:0] word_index(input logic [ADDRESS_WIDTH-1:0] addr);
        return (addr >> WORD_OFF) & ADDRESS_WIDTH'(WORDS - 1);
    endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// Fixed-latency, never-stalling response shift register with synchronous clear.
// Reports the oldest stage and the number of valid stages (the outstanding count).
module mem_resp_pipe
    import mem_pkg::*;
#(
    parameter int LATENCY = 5,
    parameter int CNT_W   = 3
) (
    input  logic             clk,
    input  logic             clear,
    input  mem_stage_t       in_stage,
    output mem_stage_t       last_stage,
    output logic [CNT_W-1:0] count
);

    // Snapshot register plus LATENCY delay stages: accept at edge N, visible after edge N+LATENCY.
    localparam int DEPTH = LATENCY + 1;

    mem_stage_t       stage_q [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign count_d = count_q + CNT_W'(in_stage.valid) - CNT_W'(stage_q[DEPTH-1].valid);

    // NOTE: non-blocking assignments make every stage read its neighbour's pre-edge value, so the loop shifts by exactly one.
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
            count_q <= '0;
        end else begin
            stage_q[0] <= in_stage;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            count_q <= count_d;
        end
    end

    assign last_stage = stage_q[DEPTH-1];
    assign count      = count_q;

endmodule

// File: rtl/pipelined_memory.sv
// Line-organised main memory with valid/ready requests, in-order fixed-latency responses,
// and both full-line and single-word stores. Every accepted request produces one response.
module pipelined_memory
    import mem_pkg::*;
#(
    parameter int LINES           = 32,
    parameter int LATENCY         = 5,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_store,
    input  logic                        req_line,
    input  logic [ADDRESS_WIDTH-1:0]    address,
    input  logic [FILL_DATA_WIDTH-1:0]  evict_data,
    input  logic [STORE_DATA_WIDTH-1:0] store_data,
    output logic                        resp_valid,
    output logic                        resp_store,
    output logic [ADDRESS_WIDTH-1:0]    resp_address,
    output logic [FILL_DATA_WIDTH-1:0]  fill_data
);

    localparam int LINE_W = $clog2(LINES);
    localparam int WIDX_W = $clog2(WORDS);
    localparam int CNT_W  = $clog2(LATENCY + 2);

    logic [FILL_DATA_WIDTH-1:0] mem_q [LINES];
    logic [LINE_W-1:0]          line_idx;
    logic [WIDX_W-1:0]          word_idx;
    logic [WORDS-1:0]           word_we;
    logic                       accept;
    mem_stage_t                 in_stage;
    mem_stage_t                 last_stage;
    logic [CNT_W-1:0]           count;

    assign line_idx = LINE_W'(line_index(address, LINES));
    assign word_idx = WIDX_W'(word_index(address));

    // A retiring stage frees its slot at the same edge, so a full pipe can still accept.
    assign req_ready = ~reset & ((count < CNT_W'(MAX_OUTSTANDING)) | last_stage.valid);
    assign accept    = req_valid & req_ready;

    // NOTE: every output of this block gets a default first so no path leaves it unassigned and a latch is never inferred.
    always_comb begin
        in_stage = '0;
        word_we  = '0;
        if (accept) begin
            in_stage.valid   = 1'b1;
            in_stage.store   = req_store;
            in_stage.address = address;
            if (!req_store) begin
                in_stage.data = mem_q[line_idx];
            end else begin
                word_we = req_line ? '1 : (WORDS'(1) << word_idx);
            end
        end
    end

    // NOTE: the line array is deliberately cleared on reset (committed stores must vanish), so it is built from flops, not a RAM macro.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int l = 0; l < LINES; l++) mem_q[l] <= '0;
        end else begin
            for (int w = 0; w < WORDS; w++) begin
                if (word_we[w]) begin
                    mem_q[line_idx][w*STORE_DATA_WIDTH +: STORE_DATA_WIDTH] <=
                        req_line ? evict_data[w*STORE_DATA_WIDTH +: STORE_DATA_WIDTH] : store_data;
                end
            end
        end
    end

    mem_resp_pipe #(
        .LATENCY (LATENCY),
        .CNT_W   (CNT_W)
    ) u_resp_pipe (
        .clk        (clk),
        .clear      (reset),
        .in_stage   (in_stage),
        .last_stage (last_stage),
        .count      (count)
    );

    assign resp_valid   = last_stage.valid & ~reset;
    assign resp_store   = last_stage.store & ~reset;
    assign resp_address = reset ? '0 : last_stage.address;
    assign fill_data    = reset ? '0 : last_stage.data;

endmodule

// File: tb/tb_pipelined_memory.sv
// Self-checking bench: directed vector table, throughput/reset sequences and random traffic,
// all scored against a transaction-level model (line array plus queue of timed expected responses).
module tb_pipelined_memory;

    localparam int FW    = 128;
    localparam int SW    = 32;
    localparam int AW    = 32;
    localparam int LINES = 32;
    localparam int LAT   = 5;
    localparam int MAXO  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_store;
    logic          req_line;
    logic [AW-1:0] address;
    logic [FW-1:0] evict_data;
    logic [SW-1:0] store_data;
    logic          resp_valid;
    logic          resp_store;
    logic [AW-1:0] resp_address;
    logic [FW-1:0] fill_data;

    always #5 clk = ~clk;

    pipelined_memory #(
        .LINES           (LINES),
        .LATENCY         (LAT),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_store    (req_store),
        .req_line     (req_line),
        .address      (address),
        .evict_data   (evict_data),
        .store_data   (store_data),
        .resp_valid   (resp_valid),
        .resp_store   (resp_store),
        .resp_address (resp_address),
        .fill_data    (fill_data)
    );

    typedef struct {
        int            edge_no;
        logic          store;
        logic [AW-1:0] addr;
        logic [FW-1:0] data;
        logic          has_const;
        logic [FW-1:0] const_fill;
    } exp_t;

    typedef struct {
        logic          store;
        logic          line;
        logic [AW-1:0] addr;
        logic [FW-1:0] evict;
        logic [SW-1:0] sdata;
        logic          has_exp;
        logic [FW-1:0] exp_fill;
    } vec_t;

    exp_t          exp_q[$];
    int            accept_edges[$];
    logic [FW-1:0] model_mem [LINES];
    vec_t          vecs [9];
    int            exp_off [8] = '{0, 1, 2, 3, 6, 7, 8, 9};
    int            edge_cnt;
    logic          exp_ready;
    logic          last_acc;
    int            n_checks;
    int            n_fail;

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, req, edge_cnt);
        end
    endtask

    // Compare outputs of the current cycle against the model and compute the expected ready.
    task automatic observe();
        logic due;
        exp_t e;
        due = !reset && exp_q.size() > 0 && (exp_q[0].edge_no + LAT == edge_cnt);
        exp_ready = !reset && ((exp_q.size() < MAXO) || due);
        check("req_ready", req_ready, exp_ready);
        check("resp_valid", resp_valid, due);
        if (reset) begin
            check("reset_resp_store", resp_store, 1'b0);
            check("reset_resp_address", resp_address, '0);
            check("reset_fill_data", fill_data, '0);
        end
        if (due) begin
            e = exp_q.pop_front();
            check("resp_store", resp_store, e.store);
            check("resp_address", resp_address, e.addr);
            check("fill_data", fill_data, e.data);
            if (e.has_const) check("fill_const", fill_data, e.const_fill);
        end
    endtask

    // One clock: drive at negedge, update the model at posedge, check at the following negedge.
    task automatic tick(input logic v, input logic st, input logic ln, input logic [AW-1:0] a,
                        input logic [FW-1:0] ev, input logic [SW-1:0] sd,
                        input logic hc, input logic [FW-1:0] cf);
        logic acc;
        int   li;
        int   wi;
        exp_t e;
        req_valid  = v;
        req_store  = st;
        req_line   = ln;
        address    = a;
        evict_data = ev;
        store_data = sd;
        acc = v & exp_ready;
        @(posedge clk);
        edge_cnt++;
        if (reset) begin
            for (int l = 0; l < LINES; l++) model_mem[l] = '0;
            exp_q.delete();
            acc = 1'b0;
        end else if (acc) begin
            li = int'((a / (FW / 8)) % LINES);
            wi = int'((a / (SW / 8)) % (FW / SW));
            e.edge_no    = edge_cnt;
            e.store      = st;
            e.addr       = a;
            e.has_const  = hc;
            e.const_fill = cf;
            if (st) begin
                if (ln) model_mem[li] = ev;
                else    model_mem[li][wi*SW +: SW] = sd;
                e.data = '0;
            end else begin
                e.data = model_mem[li];
            end
            exp_q.push_back(e);
            accept_edges.push_back(edge_cnt);
        end
        last_acc = acc;
        @(negedge clk);
        observe();
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    // Hold the request valid until the model says it was accepted.
    task automatic issue(input logic st, input logic ln, input logic [AW-1:0] a,
                         input logic [FW-1:0] ev, input logic [SW-1:0] sd,
                         input logic hc, input logic [FW-1:0] cf);
        for (int n = 0; n < 50; n++) begin
            tick(1'b1, st, ln, a, ev, sd, hc, cf);
            if (last_acc) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL issue_timeout: request at %h not accepted within 50 cycles", a);
    endtask

    task automatic drain();
        for (int n = 0; n < 50 && exp_q.size() > 0; n++) idle();
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d responses still pending", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        idle();
        reset = 1'b0;
        exp_ready = (exp_q.size() < MAXO);
        #1;
        check("ready_after_reset", req_ready, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          hold;
        logic          v;
        logic          st;
        logic          ln;
        logic [AW-1:0] a;
        logic [FW-1:0] ev;
        logic [SW-1:0] sd;

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_line   = 1'b0;
        address    = '0;
        evict_data = '0;
        store_data = '0;
        edge_cnt   = 0;
        exp_ready  = 1'b0;
        last_acc   = 1'b0;
        n_checks   = 0;
        n_fail     = 0;
        for (int l = 0; l < LINES; l++) model_mem[l] = '0;

        vecs[0] = '{1'b1, 1'b0, 32'h0000_0024, '0, 32'hDEADBEEF, 1'b0, '0};
        vecs[1] = '{1'b0, 1'b0, 32'h0000_0020, '0, '0, 1'b1,
                    128'h00000000_00000000_DEADBEEF_00000000};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0040, 128'h01234567_89ABCDEF_FEDCBA98_76543210, '0, 1'b0, '0};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_004C, '0, '0, 1'b1,
                    128'h01234567_89ABCDEF_FEDCBA98_76543210};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0048, '0, 32'h55AA55AA, 1'b0, '0};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_0040, '0, '0, 1'b1,
                    128'h01234567_55AA55AA_FEDCBA98_76543210};
        vecs[6] = '{1'b1, 1'b0, 32'h0000_0010, '0, 32'h11111111, 1'b0, '0};
        vecs[7] = '{1'b1, 1'b0, 32'h8000_0210, '0, 32'h22222222, 1'b0, '0};
        vecs[8] = '{1'b0, 1'b0, 32'h0000_0010, '0, '0, 1'b1,
                    128'h00000000_00000000_00000000_22222222};

        do_reset();

        for (int i = 0; i < 9; i++)
            issue(vecs[i].store, vecs[i].line, vecs[i].addr, vecs[i].evict, vecs[i].sdata,
                  vecs[i].has_exp, vecs[i].exp_fill);
        drain();

        // Back-to-back loads into a full pipe: four accepts, a two-cycle stall, then accept-on-retire.
        accept_edges.delete();
        for (int i = 0; i < 8; i++)
            issue(1'b0, 1'b0, 32'h0000_0100 + 32'(i * 16), '0, '0, 1'b0, '0);
        for (int i = 0; i < 8; i++)
            check("accept_offset", 128'(accept_edges[i] - accept_edges[0]), 128'(exp_off[i]));
        drain();

        // Reset with three loads in flight after a committed store.
        issue(1'b1, 1'b0, 32'h0000_0100, '0, 32'h0BADF00D, 1'b0, '0);
        for (int i = 0; i < 3; i++) issue(1'b0, 1'b0, 32'h0000_0100, '0, '0, 1'b0, '0);
        do_reset();
        for (int i = 0; i < 8; i++) idle();
        issue(1'b0, 1'b0, 32'h0000_0100, '0, '0, 1'b1, '0);
        drain();

        hold = 1'b0;
        v = 1'b0; st = 1'b0; ln = 1'b0; a = '0; ev = '0; sd = '0;
        for (int c = 0; c < 400; c++) begin
            if (!hold) begin
                v  = ($urandom_range(0, 9) < 7);
                st = ($urandom_range(0, 9) < 4);
                ln = 1'($urandom_range(0, 1));
                a  = $urandom();
                ev = {$urandom(), $urandom(), $urandom(), $urandom()};
                sd = $urandom();
            end
            tick(v, st, ln, a, ev, sd, 1'b0, '0);
            hold = v && !last_acc;
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
